// File: rtl/drop_controller_pkg.sv
// Shared Connect Four constants and the turn-sequencer state type.
package c4_pkg;

  localparam int unsigned NUM_ROWS = 16;
  localparam int unsigned NUM_COLS = 16;

  localparam logic PLAYER_RED = 1'b0;
  localparam logic PLAYER_GRN = 1'b1;

  typedef enum logic [2:0] {IDLE, PLACE, FALL, SWAP, OVER} ctrl_state_t;

endpackage

// File: rtl/drop_controller_if.sv
// Button/board inputs and turn status outputs of the drop controller.
interface drop_controller_if #(
  parameter int unsigned NUM_COLS = 16
);
  localparam int unsigned CW = $clog2(NUM_COLS);

  logic                btn_left;
  logic                btn_right;
  logic                btn_drop;
  logic [NUM_COLS-1:0] col_full;
  logic                win;
  logic                player;
  logic [CW-1:0]       cursor;
  logic [NUM_COLS-1:0] dropping;
  logic [NUM_COLS-1:0] placement;
  logic                busy;
  logic                turn_done;
  logic                game_over;
  logic                draw;

  modport master (
    output btn_left, btn_right, btn_drop, col_full, win,
    input  player, cursor, dropping, placement, busy, turn_done, game_over, draw
  );

  modport slave (
    input  btn_left, btn_right, btn_drop, col_full, win,
    output player, cursor, dropping, placement, busy, turn_done, game_over, draw
  );

endinterface

// File: rtl/drop_controller_cursor_ctrl.sv
// Wrap-around cursor column register; moves only while en_i is high.
module cursor_ctrl #(
  parameter int unsigned NUM_COLS = 16,
  localparam int unsigned CW = $clog2(NUM_COLS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          left_i,
  input  logic          right_i,
  output logic [CW-1:0] cursor_o
);

  localparam logic [CW-1:0] LastCol = CW'(NUM_COLS - 1);

  logic [CW-1:0] cursor_q, cursor_d;

  always_comb begin
    cursor_d = cursor_q;
    if (en_i && left_i && !right_i) begin
      cursor_d = (cursor_q == '0) ? LastCol : cursor_q - CW'(1);
    end else if (en_i && right_i && !left_i) begin
      cursor_d = (cursor_q == LastCol) ? '0 : cursor_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cursor_q <= '0;
    end else begin
      cursor_q <= cursor_d;
    end
  end

  assign cursor_o = cursor_q;

endmodule

// File: rtl/drop_controller.sv
// Connect Four turn sequencer: cursor, current player, drop timing, game end.
// Optional idle turn timeout enabled by defining TURN_TIMEOUT_EN.
module drop_controller #(
  parameter int unsigned NUM_COLS       = c4_pkg::NUM_COLS,
  parameter int unsigned DROP_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              RST,
  drop_controller_if.slave  bus
);
  import c4_pkg::*;

  localparam int unsigned CW   = $clog2(NUM_COLS);
  localparam int unsigned CntW = $clog2(DROP_CYCLES + 1);

  if (DROP_CYCLES < NUM_ROWS - 1) begin : g_bad_drop
    $error("DROP_CYCLES too short for a piece to reach the bottom row");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  ctrl_state_t         state_q;
  logic [CntW-1:0]     fall_cnt_q;
  logic                player_q;
  logic                draw_q;
  logic [CW-1:0]       cursor;
  logic [NUM_COLS-1:0] cursor_oh;
  logic                in_idle, drop_ok, move_en, accepted;
  logic                swap_pass, timeout_pass, turn_done;

  assign in_idle  = (state_q == IDLE);
  assign drop_ok  = in_idle && bus.btn_drop && !bus.col_full[cursor];
  // Any drop press, even into a full column, suppresses cursor movement.
  assign move_en  = in_idle && !bus.btn_drop;
  assign accepted = drop_ok || (move_en && (bus.btn_left ^ bus.btn_right));

  cursor_ctrl #(
    .NUM_COLS (NUM_COLS)
  ) u_cursor (
    .clk_i    (clk),
    .rst_i    (RST),
    .en_i     (move_en),
    .left_i   (bus.btn_left),
    .right_i  (bus.btn_right),
    .cursor_o (cursor)
  );

  assign swap_pass = (state_q == SWAP) && !bus.win && !(&bus.col_full);

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_cnt_q;

  assign timeout_pass = in_idle && !accepted && (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside IDLE so every entry into IDLE starts a fresh count.
  always_ff @(posedge clk) begin
    if (RST || !in_idle || accepted || timeout_pass) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + TW'(1);
    end
  end
`else
  assign timeout_pass = 1'b0;
`endif

  assign turn_done = swap_pass || timeout_pass;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= IDLE;
      fall_cnt_q <= '0;
      player_q   <= PLAYER_RED;
      draw_q     <= 1'b0;
    end else begin
      if (turn_done) player_q <= ~player_q;
      case (state_q)
        IDLE:  if (drop_ok) state_q <= PLACE;
        PLACE: begin
          state_q    <= FALL;
          fall_cnt_q <= '0;
        end
        FALL: begin
          if (fall_cnt_q == CntW'(DROP_CYCLES - 1)) state_q <= SWAP;
          else fall_cnt_q <= fall_cnt_q + CntW'(1);
        end
        SWAP: begin
          if (bus.win) begin
            state_q <= OVER;
          end else if (&bus.col_full) begin
            state_q <= OVER;
            draw_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        OVER:    state_q <= OVER;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cursor_oh     = NUM_COLS'(1) << cursor;
  assign bus.player    = player_q;
  assign bus.cursor    = cursor;
  assign bus.dropping  = in_idle ? cursor_oh : '0;
  assign bus.placement = (state_q == PLACE) ? cursor_oh : '0;
  assign bus.busy      = (state_q == PLACE) || (state_q == FALL) || (state_q == SWAP);
  assign bus.turn_done = turn_done;
  assign bus.game_over = (state_q == OVER);
  assign bus.draw      = draw_q;

endmodule

// File: tb/tb_drop_controller.sv
// Randomized scoreboard bench for drop_controller against a cycle-level turn model.
module tb_drop_controller;

  localparam int unsigned NC = 16;
  localparam int unsigned DC = 16;

  typedef struct packed {
    logic        player;
    logic [3:0]  cursor;
    logic [15:0] dropping;
    logic [15:0] placement;
    logic        busy;
    logic        turn_done;
    logic        game_over;
    logic        draw;
  } snap_t;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  drop_controller_if #(.NUM_COLS(NC)) bus ();

  drop_controller #(
    .NUM_COLS       (NC),
    .DROP_CYCLES    (DC),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  snap_t exp_q[$];

  // Model: mode 0 = waiting for input, 1 = piece in flight (t cycles since drop), 2 = game over.
  int   m_mode, m_t, m_cursor;
  logic m_player, m_draw;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_cursor = 0; m_player = 1'b0; m_draw = 1'b0;
  endtask

  task automatic step(input logic rst, input logic l, input logic r, input logic d,
                      input logic [15:0] full, input logic w);
    snap_t       e;
    logic [15:0] oh;
    RST = rst; bus.btn_left = l; bus.btn_right = r; bus.btn_drop = d;
    bus.col_full = full; bus.win = w;
    oh          = 16'(1) << m_cursor;
    e.player    = m_player;
    e.cursor    = 4'(m_cursor);
    e.dropping  = (m_mode == 0) ? oh : 16'h0;
    e.placement = (m_mode == 1 && m_t == 1) ? oh : 16'h0;
    e.busy      = (m_mode == 1);
    e.turn_done = (m_mode == 1 && m_t == DC + 2 && !w && full != 16'hFFFF);
    e.game_over = (m_mode == 2);
    e.draw      = m_draw;
    exp_q.push_back(e);
    if (rst) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (d) begin
        if (!full[m_cursor]) begin m_mode = 1; m_t = 1; end
      end else if (l != r) begin
        m_cursor = (m_cursor + (r ? 1 : NC - 1)) % NC;
      end
    end else if (m_mode == 1) begin
      if (m_t == DC + 2) begin
        if (w) m_mode = 2;
        else if (full == 16'hFFFF) begin m_mode = 2; m_draw = 1'b1; end
        else begin m_player = ~m_player; m_mode = 0; end
      end else begin
        m_t++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [15:0] full, input logic w);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, full, w);
  endtask

  // Monitor: compare every presented output cycle against the oldest expectation.
  initial begin
    snap_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.player, bus.cursor, bus.dropping, bus.placement, bus.busy,
             bus.turn_done, bus.game_over, bus.draw};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs @%0t: got p=%0b cur=%0d drop=%h plc=%h busy=%0b td=%0b go=%0b dr=%0b want p=%0b cur=%0d drop=%h plc=%h busy=%0b td=%0b go=%0b dr=%0b",
                   $time, a.player, a.cursor, a.dropping, a.placement, a.busy, a.turn_done,
                   a.game_over, a.draw, e.player, e.cursor, e.dropping, e.placement, e.busy,
                   e.turn_done, e.game_over, e.draw);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rst, l, r, d, w;
    logic [15:0] full;
    RST = 1'b1; bus.btn_left = 0; bus.btn_right = 0; bus.btn_drop = 0;
    bus.col_full = '0; bus.win = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Cursor movement and wrap.
    repeat (3) step(0, 0, 1, 0, 16'h0, 0);
    idle(1, 16'h0, 0);
    repeat (4) step(0, 1, 0, 0, 16'h0, 0);
    step(0, 1, 1, 0, 16'h0, 0);
    repeat (4) step(0, 0, 1, 0, 16'h0, 0);
    // Full drop cycle at column 3.
    step(0, 0, 0, 1, 16'h0, 0);
    idle(DC + 4, 16'h0, 0);
    // Drop into a full column is ignored, and blocks a simultaneous move.
    step(0, 0, 0, 1, 16'h0008, 0);
    step(0, 0, 1, 1, 16'h0008, 0);
    idle(1, 16'h0008, 0);
    // Win ends the game; buttons ignored until reset.
    step(0, 0, 0, 1, 16'h0, 0);
    idle(DC + 2, 16'h0, 1);
    step(0, 0, 1, 0, 16'h0, 0);
    step(0, 0, 0, 1, 16'h0, 0);
    idle(2, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    idle(1, 16'h0, 0);
    // Reset during FALL at count 5.
    step(0, 0, 1, 0, 16'h0, 0);
    step(0, 0, 0, 1, 16'h0, 0);
    idle(6, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    idle(2, 16'h0, 0);
    // Board fills during the fall: draw.
    step(0, 0, 0, 1, 16'h0, 0);
    idle(DC + 2, 16'hFFFF, 0);
    idle(2, 16'hFFFF, 0);
    step(1, 0, 0, 0, 16'h0, 0);

    for (int i = 0; i < 3000; i++) begin
      rst  = (m_mode == 2) ? ($urandom_range(19) == 0) : ($urandom_range(299) == 0);
      l    = ($urandom_range(3) == 0);
      r    = ($urandom_range(3) == 0);
      d    = ($urandom_range(4) == 0);
      full = ($urandom_range(63) == 0) ? 16'hFFFF : 16'($urandom & $urandom & $urandom);
      w    = ($urandom_range(15) == 0);
      step(rst, l, r, d, full, w);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
